// File: rtl/alarm_bank_if.sv
// Front-panel / timebase bundle for alarm_bank: running time and edit levels in,
// selected setting, per-channel enables and ring request out.
interface alarm_bank_if #(
  parameter int CHANNELS = 4,
  parameter int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                sec_tick;
  logic [5:0]          cur_second;
  logic [5:0]          cur_minute;
  logic [5:0]          cur_hour;
  logic [SW-1:0]       sel;
  logic                minute_set;
  logic                hour_set;
  logic                dec;
  logic                enable_set;
  logic                stop;
  logic                snooze;
  logic [5:0]          second_data;
  logic [5:0]          minute_data;
  logic [5:0]          hour_data;
  logic [CHANNELS-1:0] enable_data;
  logic                ring;
  logic [SW-1:0]       ring_channel;

  modport master (
    output sec_tick, cur_second, cur_minute, cur_hour, sel,
           minute_set, hour_set, dec, enable_set, stop, snooze,
    input  second_data, minute_data, hour_data, enable_data, ring, ring_channel
  );

  modport slave (
    input  sec_tick, cur_second, cur_minute, cur_hour, sel,
           minute_set, hour_set, dec, enable_set, stop, snooze,
    output second_data, minute_data, hour_data, enable_data, ring, ring_channel
  );
endinterface

// File: rtl/alarm_bank.sv
// Multi-channel hour/minute alarm store with per-channel enable and a
// ring / snooze / auto-timeout FSM driving the buzzer request.
module alarm_bank #(
  parameter int CHANNELS       = 4,
  parameter int HOUR_MAX       = 23,
  parameter int MINUTE_MAX     = 59,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic         clock,
  input  logic         reset,
  alarm_bank_if.slave  bus
);
  localparam int SW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RCW = $clog2(RING_SECONDS + 1);
  localparam int SCW = $clog2(SNOOZE_SECONDS + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic down,
                                            input logic [5:0] vmax);
    if (down) return (v == 6'd0) ? vmax : v - 6'd1;
    return (v == vmax) ? 6'd0 : v + 6'd1;
  endfunction

  logic min_prev_q, hr_prev_q, en_prev_q, stop_prev_q, snz_prev_q;
  logic min_ev, hr_ev, en_ev, stop_ev, snz_ev;

  logic [CHANNELS-1:0][5:0] min_q, min_d, hr_q, hr_d;
  logic [CHANNELS-1:0]      en_q, en_d;

  state_t         state_q;
  logic           ring_q;
  logic [SW-1:0]  ring_ch_q;
  logic [RCW-1:0] ring_cnt_q;
  logic [SCW-1:0] snz_cnt_q;

  logic          sel_ok;
  logic [SW-1:0] sel_idx;
  logic          match, drop_ev;
  logic [SW-1:0] match_ch;

  assign min_ev  = bus.minute_set & ~min_prev_q;
  assign hr_ev   = bus.hour_set   & ~hr_prev_q;
  assign en_ev   = bus.enable_set & ~en_prev_q;
  assign stop_ev = bus.stop       & ~stop_prev_q;
  assign snz_ev  = bus.snooze     & ~snz_prev_q;

  // Out-of-range selects neither edit nor display anything but channel 0.
  assign sel_ok  = int'(bus.sel) < CHANNELS;
  assign sel_idx = sel_ok ? bus.sel : '0;

  // Turning off the channel that owns the current ring/snooze cancels it.
  assign drop_ev = en_ev && sel_ok && (sel_idx == ring_ch_q) && en_q[sel_idx];

  always_comb begin
    min_d = min_q;
    hr_d  = hr_q;
    en_d  = en_q;
    if (sel_ok) begin
      if (min_ev) min_d[sel_idx] = step_field(min_q[sel_idx], bus.dec, 6'(MINUTE_MAX));
      if (hr_ev)  hr_d[sel_idx]  = step_field(hr_q[sel_idx], bus.dec, 6'(HOUR_MAX));
      if (en_ev)  en_d[sel_idx]  = ~en_q[sel_idx];
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    match    = 1'b0;
    match_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (en_q[i] && (hr_q[i] == bus.cur_hour) && (min_q[i] == bus.cur_minute)) begin
        match    = 1'b1;
        match_ch = SW'(i);
      end
    end
    if (!(bus.sec_tick && (bus.cur_second == 6'd0))) match = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_prev_q  <= 1'b0;
      hr_prev_q   <= 1'b0;
      en_prev_q   <= 1'b0;
      stop_prev_q <= 1'b0;
      snz_prev_q  <= 1'b0;
      min_q       <= '0;
      hr_q        <= '0;
      en_q        <= '0;
    end else begin
      min_prev_q  <= bus.minute_set;
      hr_prev_q   <= bus.hour_set;
      en_prev_q   <= bus.enable_set;
      stop_prev_q <= bus.stop;
      snz_prev_q  <= bus.snooze;
      min_q       <= min_d;
      hr_q        <= hr_d;
      en_q        <= en_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_q     <= 1'b0;
      ring_ch_q  <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_q    <= RING;
            ring_q     <= 1'b1;
            ring_ch_q  <= match_ch;
            ring_cnt_q <= '0;
          end
        end
        RING: begin
          if (stop_ev || drop_ev) begin
            state_q <= IDLE;
            ring_q  <= 1'b0;
          end else if (snz_ev) begin
            state_q   <= SNOOZE;
            ring_q    <= 1'b0;
            snz_cnt_q <= SCW'(SNOOZE_SECONDS);
          end else if (bus.sec_tick) begin
            ring_cnt_q <= ring_cnt_q + RCW'(1);
            if (ring_cnt_q == RCW'(RING_SECONDS - 1)) begin
              state_q <= IDLE;
              ring_q  <= 1'b0;
            end
          end
        end
        SNOOZE: begin
          if (stop_ev || drop_ev) begin
            state_q <= IDLE;
          end else if (bus.sec_tick) begin
            snz_cnt_q <= snz_cnt_q - SCW'(1);
            if (snz_cnt_q == SCW'(1)) begin
              state_q    <= RING;
              ring_q     <= 1'b1;
              ring_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.second_data  = 6'd0;
  assign bus.minute_data  = min_q[sel_idx];
  assign bus.hour_data    = hr_q[sel_idx];
  assign bus.enable_data  = en_q;
  assign bus.ring         = ring_q;
  assign bus.ring_channel = ring_ch_q;
endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: edit table, hand-written ring/snooze/reset
// sequences, then randomized traffic against a behavioural alarm-clock model.
module tb_alarm_bank;
  localparam int CH = 4;
  localparam int RS = 60;
  localparam int SS = 300;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alarm_bank_if #(.CHANNELS(CH)) bus ();

  alarm_bank #(
    .CHANNELS(CH), .HOUR_MAX(23), .MINUTE_MAX(59),
    .RING_SECONDS(RS), .SNOOZE_SECONDS(SS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: the alarm clock as a user sees it.
  int m_hr[CH];
  int m_min[CH];
  bit m_en[CH];
  int m_mode;    // 0 quiet, 1 ringing, 2 snoozing
  int m_rch;
  int m_rsec;    // seconds rung so far
  int m_sleft;   // snooze seconds left
  bit p_min, p_hr, p_en, p_stop, p_snz;

  typedef struct {
    int sel;
    bit h;
    bit m;
    bit d;
    int n;
    int eh;
    int em;
  } edit_t;
  edit_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_hr[i] = 0; m_min[i] = 0; m_en[i] = 1'b0;
    end
    m_mode = 0; m_rch = 0; m_rsec = 0; m_sleft = 0;
    p_min = 0; p_hr = 0; p_en = 0; p_stop = 0; p_snz = 0;
  endtask

  task automatic model_update();
    bit ev_m, ev_h, ev_e, ev_s, ev_z, selok, drop;
    int s, hit;
    if (reset) begin
      model_reset();
      return;
    end
    ev_m = bus.minute_set && !p_min;
    ev_h = bus.hour_set && !p_hr;
    ev_e = bus.enable_set && !p_en;
    ev_s = bus.stop && !p_stop;
    ev_z = bus.snooze && !p_snz;
    s = int'(bus.sel);
    selok = (s < CH);
    hit = -1;
    if (bus.sec_tick && bus.cur_second == 6'd0)
      for (int i = CH - 1; i >= 0; i--)
        if (m_en[i] && m_hr[i] == int'(bus.cur_hour) && m_min[i] == int'(bus.cur_minute))
          hit = i;
    drop = ev_e && selok && (s == m_rch) && m_en[s];
    case (m_mode)
      0: if (hit >= 0) begin m_mode = 1; m_rch = hit; m_rsec = 0; end
      1: begin
        if (ev_s || drop) m_mode = 0;
        else if (ev_z) begin m_mode = 2; m_sleft = SS; end
        else if (bus.sec_tick) begin
          m_rsec++;
          if (m_rsec >= RS) m_mode = 0;
        end
      end
      2: begin
        if (ev_s || drop) m_mode = 0;
        else if (bus.sec_tick) begin
          m_sleft--;
          if (m_sleft == 0) begin m_mode = 1; m_rsec = 0; end
        end
      end
      default: ;
    endcase
    if (selok) begin
      if (ev_m) m_min[s] = bus.dec ? (m_min[s] + 59) % 60 : (m_min[s] + 1) % 60;
      if (ev_h) m_hr[s]  = bus.dec ? (m_hr[s] + 23) % 24 : (m_hr[s] + 1) % 24;
      if (ev_e) m_en[s]  = !m_en[s];
    end
    p_min = bus.minute_set; p_hr = bus.hour_set; p_en = bus.enable_set;
    p_stop = bus.stop; p_snz = bus.snooze;
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit tick);
    bus.cur_hour = 6'(h); bus.cur_minute = 6'(m); bus.cur_second = 6'(s);
    bus.sec_tick = tick;
  endtask

  task automatic pulse_edit(input int sel, input bit h, input bit m, input bit d);
    bus.sel = 2'(sel); bus.dec = d;
    bus.hour_set = h; bus.minute_set = m;
    step();
    bus.hour_set = 1'b0; bus.minute_set = 1'b0;
    step();
  endtask

  task automatic pulse_enable(input int sel);
    bus.sel = 2'(sel);
    bus.enable_set = 1'b1;
    step();
    bus.enable_set = 1'b0;
    step();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [CH-1:0] exp_en;

    tbl[0]  = '{2, 1'b1, 1'b0, 1'b1, 3, 21, 0};
    tbl[1]  = '{0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[2]  = '{1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[3]  = '{1, 1'b0, 1'b1, 1'b0, 60, 0, 0};
    tbl[4]  = '{1, 1'b1, 1'b1, 1'b0, 1, 1, 1};
    tbl[5]  = '{1, 1'b0, 1'b1, 1'b1, 2, 1, 59};
    tbl[6]  = '{1, 1'b1, 1'b1, 1'b1, 1, 0, 58};
    tbl[7]  = '{3, 1'b1, 1'b0, 1'b0, 24, 0, 0};
    tbl[8]  = '{3, 1'b1, 1'b0, 1'b1, 1, 23, 0};
    tbl[9]  = '{1, 1'b1, 1'b0, 1'b0, 7, 7, 58};
    tbl[10] = '{1, 1'b0, 1'b1, 1'b1, 28, 7, 30};
    tbl[11] = '{3, 1'b1, 1'b0, 1'b0, 8, 7, 0};
    tbl[12] = '{3, 1'b0, 1'b1, 1'b1, 30, 7, 30};
    tbl[13] = '{2, 1'b0, 1'b0, 1'b0, 0, 21, 0};

    reset = 1'b1;
    bus.sel = '0; bus.minute_set = 0; bus.hour_set = 0; bus.dec = 0;
    bus.enable_set = 0; bus.stop = 0; bus.snooze = 0;
    set_time(0, 0, 0, 0);
    model_reset();
    step();
    step();
    reset = 1'b0;

    for (int c = 0; c < CH; c++) begin
      bus.sel = 2'(c);
      #1;
      chk($sformatf("reset_hour%0d", c), bus.hour_data, 0);
      chk($sformatf("reset_min%0d", c), bus.minute_data, 0);
    end
    chk("reset_enable", bus.enable_data, 0);
    chk("reset_ring", bus.ring, 0);
    chk("reset_ring_channel", bus.ring_channel, 0);
    chk("second_data", bus.second_data, 0);

    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < tbl[r].n; k++) pulse_edit(tbl[r].sel, tbl[r].h, tbl[r].m, tbl[r].d);
      bus.sel = 2'(tbl[r].sel);
      #1;
      chk($sformatf("edit%0d_hour", r), bus.hour_data, tbl[r].eh);
      chk($sformatf("edit%0d_min", r), bus.minute_data, tbl[r].em);
    end

    // Channel 2 is at 21:00 but disabled.
    set_time(21, 0, 0, 1);
    step();
    chk("disabled_no_ring", bus.ring, 0);
    set_time(0, 0, 5, 0);

    pulse_enable(1);
    pulse_enable(3);
    chk("enable_1_3", bus.enable_data, 4'b1010);

    // Ring with auto-timeout.
    set_time(7, 30, 0, 1);
    step();
    chk("ring_rise", bus.ring, 1);
    chk("ring_lowest_ch", bus.ring_channel, 1);
    set_time(7, 30, 5, 1);
    repeat (RS - 1) step();
    chk("ring_before_timeout", bus.ring, 1);
    step();
    chk("ring_timeout", bus.ring, 0);
    bus.sec_tick = 0;
    step();
    chk("ring_stays_off", bus.ring, 0);

    // Snooze and wake.
    set_time(7, 30, 0, 1);
    step();
    chk("ring_rise2", bus.ring, 1);
    set_time(7, 30, 5, 0);
    bus.snooze = 1;
    step();
    chk("snooze_drop", bus.ring, 0);
    bus.snooze = 0;
    bus.sec_tick = 1;
    repeat (SS - 1) step();
    chk("snooze_before_wake", bus.ring, 0);
    step();
    chk("snooze_wake", bus.ring, 1);
    chk("snooze_wake_ch", bus.ring_channel, 1);
    bus.sec_tick = 0;
    bus.stop = 1; bus.snooze = 1;
    step();
    chk("stop_and_snooze", bus.ring, 0);
    bus.stop = 0; bus.snooze = 0;
    bus.sec_tick = 1;
    repeat (SS + 1) step();
    chk("stop_beats_snooze", bus.ring, 0);
    bus.sec_tick = 0;

    // A held stop level is a single event.
    set_time(7, 30, 0, 1);
    step();
    chk("ring_rise3", bus.ring, 1);
    set_time(7, 30, 5, 0);
    bus.stop = 1;
    step();
    chk("stop_first_edge", bus.ring, 0);
    set_time(7, 30, 0, 1);
    step();
    chk("ring_with_stop_held", bus.ring, 1);
    set_time(7, 30, 5, 0);
    repeat (8) step();
    chk("stop_held_no_event", bus.ring, 1);
    bus.stop = 0;
    step();
    bus.stop = 1;
    step();
    chk("stop_new_edge", bus.ring, 0);
    bus.stop = 0;
    step();

    // Disabling the ringing channel cancels; the next-lowest channel then wins.
    set_time(7, 30, 0, 1);
    step();
    chk("ring_rise4", bus.ring, 1);
    set_time(7, 30, 5, 0);
    bus.sel = 2'd1; bus.enable_set = 1;
    step();
    chk("disable_drop", bus.ring, 0);
    chk("disable_enables", bus.enable_data, 4'b1000);
    bus.enable_set = 0;
    step();
    set_time(7, 30, 0, 1);
    step();
    chk("ring_ch3", bus.ring, 1);
    chk("ring_ch3_id", bus.ring_channel, 3);
    set_time(7, 30, 5, 0);
    bus.stop = 1;
    step();
    bus.stop = 0;
    step();
    pulse_enable(1);
    chk("reenable", bus.enable_data, 4'b1010);

    // Reset in the middle of a snooze.
    set_time(7, 30, 0, 1);
    step();
    chk("ring_rise5", bus.ring, 1);
    set_time(7, 30, 5, 0);
    bus.snooze = 1;
    step();
    bus.snooze = 0;
    bus.sec_tick = 1;
    repeat (SS - 2) step();
    chk("pre_reset_snooze", bus.ring, 0);
    bus.sec_tick = 0;
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
    for (int c = 0; c < CH; c++) begin
      bus.sel = 2'(c);
      #1;
      chk($sformatf("rst_hour%0d", c), bus.hour_data, 0);
      chk($sformatf("rst_min%0d", c), bus.minute_data, 0);
    end
    chk("rst_enable", bus.enable_data, 0);
    chk("rst_ring", bus.ring, 0);
    bus.sec_tick = 1;
    repeat (5) step();
    chk("no_ring_after_reset", bus.ring, 0);
    set_time(7, 30, 0, 1);
    step();
    chk("no_ring_after_reset_match", bus.ring, 0);
    bus.sec_tick = 0;

    // Asynchronous reset while ringing.
    pulse_enable(0);
    set_time(0, 0, 0, 1);
    step();
    chk("ring_ch0", bus.ring, 1);
    chk("ring_ch0_id", bus.ring_channel, 0);
    bus.sec_tick = 0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_ring", bus.ring, 0);
    #1;
    reset = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int j;
      j = $urandom_range(0, CH - 1);
      bus.sel = 2'($urandom_range(0, CH - 1));
      bus.dec = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.minute_set = ~bus.minute_set;
      if ($urandom_range(0, 3) == 0) bus.hour_set = ~bus.hour_set;
      if ($urandom_range(0, 7) == 0) bus.enable_set = ~bus.enable_set;
      if ($urandom_range(0, 63) == 0) bus.stop = ~bus.stop;
      if ($urandom_range(0, 63) == 0) bus.snooze = ~bus.snooze;
      if ($urandom_range(0, 3) == 0) begin
        bus.cur_hour = 6'(m_hr[j]);
        bus.cur_minute = 6'(m_min[j]);
      end else begin
        bus.cur_hour = 6'($urandom_range(0, 23));
        bus.cur_minute = 6'($urandom_range(0, 59));
      end
      bus.cur_second = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
      bus.sec_tick = 1'($urandom_range(0, 1));
      step();
      for (int i = 0; i < CH; i++) exp_en[i] = m_en[i];
      chk("rnd_ring", bus.ring, (m_mode == 1) ? 1 : 0);
      chk("rnd_ring_channel", bus.ring_channel, m_rch);
      chk("rnd_enable", bus.enable_data, exp_en);
      chk("rnd_hour", bus.hour_data, m_hr[bus.sel]);
      chk("rnd_min", bus.minute_data, m_min[bus.sel]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel alarm store and ringer, the parametrised successor of the single alarm register. It holds `CHANNELS` independent hour/minute alarm settings, edited one channel at a time by set pulses with increment/decrement direction. Each channel has its own enable. The block compares every enabled channel against the running time and drives a ring output with stop, snooze and auto-timeout. It sits between the front-panel button conditioning and the display mux/buzzer driver.

## Interface
- `CHANNELS`, 4: number of alarm channels (1–8); `SW = max(1, clog2(CHANNELS))`.
- `HOUR_MAX`, 23: hour wrap value.
- `MINUTE_MAX`, 59: minute wrap value.
- `RING_SECONDS`, 60: seconds the ring lasts before auto-stop.
- `SNOOZE_SECONDS`, 300: snooze delay in seconds.

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `sec_tick`  in  1  one-cycle pulse per second from the timebase.
- `cur_second`, `cur_minute`, `cur_hour`  in  6 each  running time.
- `sel`  in  SW  channel being edited/displayed; values ≥ CHANNELS are ignored (no edit, display reads channel 0).
- `minute_set`, `hour_set`  in  1  levels; a rising edge steps the selected field.
- `dec`  in  1  0 = step up, 1 = step down; sampled with the edge.
- `enable_set`  in  1  rising edge toggles the selected channel's enable.
- `stop`, `snooze`  in  1  levels; a rising edge acts on the ring FSM.
- `second_data`  out  6  constant 0.
- `minute_data`, `hour_data`  out  6 each  selected channel's setting.
- `enable_data`  out  CHANNELS  per-channel enables.
- `ring`  out  1  buzzer request.
- `ring_channel`  out  SW  channel that triggered the current ring/snooze.

## Operation
- Edge detection: one register per level input holds its previous sample. An event is current = 1 and previous = 0. A held level produces exactly one event.
- Edit: a `minute_set` event steps the selected minute; an `hour_set` event steps the selected hour.
  - Increment at max wraps to 0; decrement at 0 wraps to max.
  - Simultaneous minute and hour events both apply in the same cycle.
- Editing is legal in every FSM state and never changes the FSM.
- Match: a channel matches when it is enabled, its hour/minute equal `cur_hour`/`cur_minute`, `cur_second` = 0, and `sec_tick` = 1. If several channels match, the lowest index wins.
- Ring FSM states:
  - IDLE: `ring` = 0. A match moves to RING, latches `ring_channel`, and clears the ring counter.
  - RING: `ring` = 1. Each `sec_tick` increments the ring counter; at RING_SECONDS ticks the FSM goes to IDLE. A stop event goes to IDLE. A snooze event goes to SNOOZE and loads the snooze counter.
  - SNOOZE: `ring` = 0. Each `sec_tick` decrements the snooze counter; on reaching 0 the FSM goes to RING and clears the ring counter. A stop event goes to IDLE.
- Matches arriving in RING or SNOOZE are ignored.
- Stop has priority over snooze when both events occur in the same cycle.
- Toggling off the enable of `ring_channel` while in RING or SNOOZE returns the FSM to IDLE.
- Counter widths: `clog2(RING_SECONDS+1)` and `clog2(SNOOZE_SECONDS+1)`; no overflow is possible.

## Timing
- Reset values: every channel is 0:00, `enable_data` = 0, FSM IDLE, `ring` = 0, `ring_channel` = 0, edge registers 0.
- Reset asserted mid-ring or mid-snooze forces IDLE immediately (asynchronously).
- Edit events are visible on the data outputs one cycle after the input rises.
- `minute_data`/`hour_data` follow `sel` combinationally from the registered settings.
- `ring` rises one cycle after the matching `sec_tick` cycle.
- `ring` falls one cycle after the stop event, the snooze event, or the RING_SECONDS-th tick.
- After snooze, `ring` rises one cycle after the SNOOZE_SECONDS-th tick.

## Test plan
- Reset, then apply 3 rising `hour_set` edges with `dec` = 1 on sel = 2 → ch2 hour reads 21; ch0 and ch1 remain 0.
- Apply 60 `minute_set` edges on sel = 1 → minute reads 0. Assert minute and hour edges in the same cycle → both fields step in that cycle.
- Enable ch1 and ch3 both at 07:30, drive 07:30:00 with `sec_tick` → `ring` = 1 next cycle, `ring_channel` = 1. After 60 ticks → `ring` = 0.
- While ringing, pulse `snooze` → `ring` = 0. After 300 ticks, `ring` = 1 again. Then pulse stop and snooze in the same cycle → FSM goes to IDLE.
- Hold `stop` high for 10 cycles → exactly one stop event. A disabled channel at a matching time → no ring.
- Assert reset during SNOOZE → `ring` = 0, all settings are 0:00, and no ring follows the remaining ticks.
